// File: rtl/lsu_pkg.sv
// Shared load/store constants: funct3 access codes, bus widths and the
// request payload captured by the LSU for the duration of one transaction.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_BE_W   = 4;

    // funct3 access size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // One data-memory bus request as held on the req_* outputs
    typedef struct packed {
        logic                    we;
        logic [LSU_ADDR_W-1:0]   addr;
        logic [LSU_BE_W-1:0]     be;
        logic [LSU_DATA_W-1:0]   wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the LSU.
// Request side (live inputs): legality, byte enables and lane-replicated
// store data from funct3/addr_lo/wdata.
// Response side (captured values): shifts the read word down to the
// addressed lane and sign/zero-extends it.
//   mem_read, mem_write  op strobes
//   funct3, addr_lo      live access size and low address bits
//   wdata                store data
//   ld_funct3, ld_addr_lo captured size/offset used for load extraction
//   rdata                read word from the bus
//   legal_c              a single, aligned, supported op is present
//   be_c, wdata_c        byte enables and replicated store data
//   load_c               extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic              legal_c,
    output logic [3:0]        be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_c
);

    logic              align_ok;
    logic              load_f3_ok;
    logic              store_f3_ok;
    logic [DATA_W-1:0] shifted;

    // Legality: exactly one strobe, funct3 supported for the direction, natural alignment
    always_comb begin
        align_ok    = 1'b0;
        load_f3_ok  = 1'b0;
        store_f3_ok = 1'b0;
        case (funct3)
            F3_B:  begin align_ok = 1'b1;              load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            F3_H:  begin align_ok = ~addr_lo[0];       load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            F3_W:  begin align_ok = (addr_lo == 2'b00); load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            F3_BU: begin align_ok = 1'b1;              load_f3_ok = 1'b1; end
            F3_HU: begin align_ok = ~addr_lo[0];       load_f3_ok = 1'b1; end
            default: ;
        endcase
        legal_c = (mem_read ^ mem_write) && align_ok
                  && (mem_read ? load_f3_ok : store_f3_ok);
    end

    // Byte enables and store lane replication
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
            end
            F3_W:    be_c = 4'hF;
            default: ;
        endcase
    end

    // Load extraction from the captured offset, then extension
    always_comb begin
        shifted = rdata >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            F3_B:    load_c = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_c = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_c = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_c = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one mem_read/mem_write from the datapath into a
// single word-aligned valid/ready request on the data-memory bus, stalls
// the core until it completes and returns extended load data.
//   clk, reset            clock, async active-high reset
//   mem_read, mem_write   op strobes from control
//   funct3, addr, wdata   access size/sign, byte address, store data
//   load_data             extended load result (valid in DONE)
//   stall, fault          combinational pipeline hold / illegal-op pulse
//   req_*                 registered bus request (valid/ready)
//   resp_valid, resp_rdata read response
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_DATA_W,
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              fault,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_be,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              capture;
    logic              load_en;
    lsu_req_t          req_q;
    logic              req_valid_q;
    logic [2:0]        cap_funct3;
    logic [1:0]        cap_addr_lo;
    logic [DATA_W-1:0] load_q;

    logic              legal_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_c;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .ld_funct3  (cap_funct3),
        .ld_addr_lo (cap_addr_lo),
        .rdata      (resp_rdata),
        .legal_c    (legal_c),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .load_c     (load_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state, capture/load strobes, stall and fault
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load_en    = 1'b0;
        stall      = 1'b0;
        fault      = 1'b0;
        case (state)
            S_IDLE: begin
                if (legal_c) begin
                    capture    = 1'b1;
                    stall      = 1'b1;
                    state_next = S_REQ;
                end else begin
                    fault = mem_read | mem_write;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (req_ready) state_next = req_q.we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (resp_valid) begin
                    load_en    = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request payload and load result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            cap_funct3  <= 3'b000;
            cap_addr_lo <= 2'b00;
            load_q      <= '0;
        end else begin
            req_valid_q <= (state_next == S_REQ);
            if (capture) begin
                req_q.we    <= mem_write;
                req_q.addr  <= {addr[ADDR_W-1:2], 2'b00};
                req_q.be    <= be_c;
                req_q.wdata <= wdata_c;
                cap_funct3  <= funct3;
                cap_addr_lo <= addr[1:0];
            end
            if (load_en) load_q <= load_c;
        end
    end

    assign req_valid = req_valid_q;
    assign req_we    = req_q.we;
    assign req_addr  = req_q.addr;
    assign req_be    = req_q.be;
    assign req_wdata = req_q.wdata;
    assign load_data = load_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops compared
// against an arithmetic reference model of the access rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        fault;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .load_data  (load_data),
        .stall      (stall),
        .fault      (fault),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model ----
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        int n;
        n = size_of(f3);
        if (rd == wr) return 1'b0;
        if (n == 0) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        return (a % n) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int k;
        n = size_of(f3);
        k = int'(a % 4);
        return 4'(((1 << n) - 1) << k);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = size_of(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wd >> (8 * (i % n)));
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = rd >> (8 * (a % 4));
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return v;
        endcase
    endfunction

    // One complete op starting in IDLE (just after a clock edge); ends in IDLE.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdata, input int rdy_dly, input int resp_dly);
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        if (!model_legal(rd, wr, f3, a)) begin
            check("fault_pulse", 32'(fault), 32'd1);
            check("stall_illegal", 32'(stall), 32'd0);
            tick();
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            check("no_req_illegal", 32'(req_valid), 32'd0);
            check("fault_cleared", 32'(fault), 32'd0);
            return;
        end
        check("fault_legal", 32'(fault), 32'd0);
        check("stall_idle", 32'(stall), 32'd1);
        e_addr = a & 32'hFFFF_FFFC;
        e_be   = model_be(f3, a);
        e_wd   = model_wdata(f3, wd);
        tick();
        // Inputs change after acceptance; captured values must hold.
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            addr       = $urandom;
            wdata      = $urandom;
            funct3     = 3'($urandom);
            resp_valid = 1'($urandom);
            resp_rdata = $urandom;
            if (i == rdy_dly) req_ready = 1'b1;
            #1;
            check("req_valid", 32'(req_valid), 32'd1);
            check("req_addr", req_addr, e_addr);
            check("req_be", 32'(req_be), 32'(e_be));
            check("req_we", 32'(req_we), 32'(wr));
            if (wr) check("req_wdata", req_wdata, e_wd);
            check("stall_req", 32'(stall), 32'd1);
            tick();
        end
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        if (!wr) begin
            for (int i = 1; i <= resp_dly; i++) begin
                #1;
                check("stall_wait", 32'(stall), 32'd1);
                check("req_valid_wait", 32'(req_valid), 32'd0);
                if (i == resp_dly) begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata;
                end
                tick();
            end
            resp_valid = 1'b0;
            resp_rdata = $urandom;
            #1;
            check("load_data", load_data, model_load(f3, a, rdata));
        end
        check("stall_done", 32'(stall), 32'd0);
        check("req_valid_done", 32'(req_valid), 32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_req_we"}, 32'(req_we), 32'd0);
        check({tag, "_req_addr"}, req_addr, 32'd0);
        check({tag, "_req_be"}, 32'(req_be), 32'd0);
        check({tag, "_req_wdata"}, req_wdata, 32'd0);
        check({tag, "_load_data"}, load_data, 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        addr       = '0;
        wdata      = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed cases
        do_op(0, 1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 1);
        do_op(1, 0, 3'd0, 32'h203, 32'h0, 32'h8011_2233, 0, 1);
        do_op(1, 0, 3'd4, 32'h203, 32'h0, 32'h8011_2233, 0, 1);
        do_op(0, 1, 3'd1, 32'h12, 32'h0000_ABCD, 32'h0, 0, 1);
        do_op(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 32'hCAFE_F00D, 5, 3);
        do_op(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 1);
        do_op(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 1);
        do_op(1, 0, 3'd5, 32'h101, 32'h0, 32'h0, 0, 1);
        do_op(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1);
        do_op(1, 0, 3'd1, 32'h22, 32'h0, 32'h9234_5678, 1, 2);
        do_op(1, 0, 3'd5, 32'h22, 32'h0, 32'h9234_5678, 0, 1);

        // Reset while waiting for a response; the late response is dropped
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h300;
        #1;
        tick();
        mem_read  = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        #2;
        check("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_rdata = 32'h1234_5678;
        tick();
        resp_valid = 1'b0;
        #1;
        check_all_zero("late_resp");
        do_op(1, 0, 3'd2, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 1);

        // Randomized ops
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            int          kind;
            bit          rd;
            bit          wr;
            a    = $urandom;
            f3   = 3'($urandom);
            kind = int'($urandom_range(0, 9));
            rd   = (kind < 5) || (kind == 9);
            wr   = (kind >= 5);
            if ($urandom_range(0, 3) != 0) begin
                if (size_of(f3) == 2) a[0] = 1'b0;
                if (size_of(f3) == 4) a[1:0] = 2'b00;
            end
            do_op(rd, wr, f3, a, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
